msh_out_port_arb: RTL and testbench
===================================

Name: msh_out_port_arb

Overview:
- Per-plane output-port scheduler for one outgoing mesh direction of a mesh node.
- Arbitrates among NUM_REQ internal sources (the NB/SB/EB/WB pass-through paths plus the local inject path) using round-robin.
- Gates each grant on a downstream credit counter, then registers the winning message onto the outgoing link.
- One instance per direction per plane; it sequences the shared outgoing link resource.

Parameters:
NUM_REQ, 5, number of requesting sources (index 0..NUM_REQ-1)
DATA_W, 64, flattened message width carried per request
MAX_CRDTS, 8, downstream buffer depth; credit counter reset value and ceiling
CNT_W, $clog2(MAX_CRDTS+1), credit counter width (derived, not overridable)

Ports:
mclk  in  1  mesh clock, all state on rising edge
i_reset_n  in  1  asynchronous active-low reset
i_req_vld  in  NUM_REQ  per-source request valid
i_req_data  in  NUM_REQ*DATA_W  per-source message; source k occupies bits [k*DATA_W +: DATA_W]
o_req_gnt  out  NUM_REQ  one-hot grant; combinational, same cycle as i_req_vld; source drops or advances its request on grant
o_vld  out  1  registered outgoing message valid
o_data  out  DATA_W  registered outgoing message
i_crdt_rtn  in  1  one credit returned by downstream this cycle
o_crdt_cnt  out  CNT_W  current available credits (registered)
o_crdt_err  out  1  sticky credit-overflow error

Behaviour:
- Reset (async assert, sync deassert handled upstream). Reset values:
  - o_vld=0, o_data=0
  - credit count = MAX_CRDTS
  - rr_ptr=0
  - o_crdt_err=0
  - o_req_gnt=0 while i_reset_n low.
- Arbitration (combinational):
  - Grant is eligible when credit count > 0 and any i_req_vld is set.
  - Winner is the first set i_req_vld scanning from rr_ptr upward, wrapping NUM_REQ-1 to 0.
  - o_req_gnt is one-hot to the winner, zero otherwise.
  - Zero credits gives zero grant, regardless of requests.
- Pointer update: on a grant to index k, rr_ptr <= (k==NUM_REQ-1) ? 0 : k+1. With no grant, rr_ptr holds.
- Output register, latency 1 cycle from grant:
  - o_vld <= |o_req_gnt; o_data <= winner's i_req_data.
  - With no grant, o_vld <= 0 and o_data holds its last value.
- Credit counter:
  - cnt_next = cnt - gnt + rtn, where gnt = |o_req_gnt and rtn = i_crdt_rtn.
  - Simultaneous grant and return: count unchanged.
  - A credit returned in cycle N is usable for a grant in cycle N+1 only; no same-cycle bypass.
  - Count never underflows, since a grant requires cnt > 0.
- Overflow: i_crdt_rtn with cnt==MAX_CRDTS and no grant → count stays MAX_CRDTS and o_crdt_err <= 1. The error is sticky until reset.
- Reset mid-operation: all state is cleared immediately. An in-flight o_vld drops asynchronously; downstream is reset in the same domain.
- Fairness: every continuously asserted requester is granted within NUM_REQ grant cycles.

Optional Feature:
- Macro: MSH_OUT_ARB_PERF_EN.
- Defined: adds output o_stall_cnt [15:0] and input i_perf_clr [1].
  - o_stall_cnt increments in each cycle where |i_req_vld==1 and cnt==0, saturating at 16'hFFFF.
  - Counter resets to 0 on i_reset_n low.
  - Synchronous clear on i_perf_clr=1; clear wins over increment.
- Undefined: the port and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Reset, then all 5 requesters held valid, no credit returns:
   - grants go 0,1,2,3,4,0,1,2 over 8 cycles; o_vld follows 1 cycle later.
   - o_crdt_cnt decrements 8→0; o_req_gnt=0 from cycle 9.
2. Credits at 0, req 3 valid, pulse i_crdt_rtn in cycle N:
   - o_crdt_cnt=1 in N+1 and gnt[3]=1 in N+1.
   - o_vld=1 in N+2 with o_data = req 3 data; count back to 0.
3. Count=4, grant and i_crdt_rtn in the same cycle → count remains 4 and o_crdt_err stays 0.
4. Count=MAX_CRDTS=8, no requests, pulse i_crdt_rtn:
   - count stays 8 and o_crdt_err=1.
   - o_crdt_err remains 1 after further normal traffic until i_reset_n is asserted.
5. rr_ptr=4, only req 1 and req 4 valid → gnt[4], then gnt[1], then gnt[4]. This checks wrap-around and pointer skip.
6. Traffic running at count=3, assert i_reset_n low mid-cycle:
   - o_vld=0, o_req_gnt=0 immediately.
   - After deassert: count=8 and the first grant goes to the lowest valid index from 0.
   - With MSH_OUT_ARB_PERF_EN defined: o_stall_cnt=0 after reset, and it counts 10 after 10 stalled cycles with credits at 0.

Source files
------------

// File: rtl/msh_out_port_arb.sv
// msh_out_port_arb: round-robin, credit-gated output-port scheduler
// for one outgoing mesh direction of one plane.
//
// Ports:
//   mclk, i_reset_n            clock, async active-low reset
//   i_req_vld  [NUM_REQ]       per-source request valid
//   i_req_data [NUM_REQ*DATA_W] source k at [k*DATA_W +: DATA_W]
//   o_req_gnt  [NUM_REQ]       one-hot combinational grant
//   o_vld, o_data              registered winning message
//   i_crdt_rtn                 one downstream credit returned
//   o_crdt_cnt [CNT_W]         available credits
//   o_crdt_err                 sticky credit-overflow flag
// Optional (MSH_OUT_ARB_PERF_EN): o_stall_cnt [16], i_perf_clr.
module msh_out_port_arb #(
  parameter int NUM_REQ   = 5,
  parameter int DATA_W    = 64,
  parameter int MAX_CRDTS = 8,
  localparam int CNT_W    = $clog2(MAX_CRDTS + 1)
) (
  input  logic                      mclk,
  input  logic                      i_reset_n,
  input  logic [NUM_REQ-1:0]        i_req_vld,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_gnt,
  output logic                      o_vld,
  output logic [DATA_W-1:0]         o_data,
  input  logic                      i_crdt_rtn,
  output logic [CNT_W-1:0]          o_crdt_cnt,
  output logic                      o_crdt_err
`ifdef MSH_OUT_ARB_PERF_EN
  ,
  output logic [15:0]               o_stall_cnt,
  input  logic                      i_perf_clr
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CRDTS);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win;
  logic [CNT_W-1:0]  cnt;
  logic              found;
  logic              gnt_any;
  logic [DATA_W-1:0] win_data;
  int                idx;

  // Scan from rr_ptr upward with wrap; first valid wins.
  // Reset low forces the grant off even before state clears.
  always_comb begin
    o_req_gnt = '0;
    win       = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && i_req_vld[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
    gnt_any = found && (cnt != '0) && i_reset_n;
    if (gnt_any) o_req_gnt[win] = 1'b1;
    win_data = i_req_data[int'(win)*DATA_W +: DATA_W];
  end

  always_ff @(posedge mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_ptr     <= '0;
      o_vld      <= 1'b0;
      o_data     <= '0;
      cnt        <= CNT_MAX;
      o_crdt_err <= 1'b0;
    end else begin
      o_vld <= gnt_any;
      if (gnt_any) begin
        o_data <= win_data;
        rr_ptr <= (win == LAST) ? '0 : win + 1'b1;
      end
      // Grant and return together cancel out.
      unique case ({gnt_any, i_crdt_rtn})
        2'b10: cnt <= cnt - 1'b1;
        2'b01: begin
          if (cnt == CNT_MAX) o_crdt_err <= 1'b1;
          else                cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_crdt_cnt = cnt;

`ifdef MSH_OUT_ARB_PERF_EN
  always_ff @(posedge mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_stall_cnt <= '0;
    end else if (i_perf_clr) begin
      o_stall_cnt <= '0;
    end else if ((|i_req_vld) && (cnt == '0)
                 && (o_stall_cnt != 16'hFFFF)) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_msh_out_port_arb.sv
// tb_msh_out_port_arb: directed self-checking bench for
// msh_out_port_arb (drive on negedge, sample #1 later).
module tb_msh_out_port_arb;

  localparam int NR = 5;
  localparam int DW = 64;
  localparam int CW = 4;

  logic             mclk = 1'b0;
  logic             i_reset_n;
  logic [NR-1:0]    i_req_vld;
  logic [NR*DW-1:0] i_req_data;
  logic [NR-1:0]    o_req_gnt;
  logic             o_vld;
  logic [DW-1:0]    o_data;
  logic             i_crdt_rtn;
  logic [CW-1:0]    o_crdt_cnt;
  logic             o_crdt_err;
`ifdef MSH_OUT_ARB_PERF_EN
  logic [15:0]      o_stall_cnt;
  logic             i_perf_clr;
`endif

  int errors = 0;
  int checks = 0;

  msh_out_port_arb dut (
    .mclk       (mclk),
    .i_reset_n  (i_reset_n),
    .i_req_vld  (i_req_vld),
    .i_req_data (i_req_data),
    .o_req_gnt  (o_req_gnt),
    .o_vld      (o_vld),
    .o_data     (o_data),
    .i_crdt_rtn (i_crdt_rtn),
    .o_crdt_cnt (o_crdt_cnt),
    .o_crdt_err (o_crdt_err)
`ifdef MSH_OUT_ARB_PERF_EN
    ,
    .o_stall_cnt(o_stall_cnt),
    .i_perf_clr (i_perf_clr)
`endif
  );

  always #5 mclk = ~mclk;

  function automatic logic [DW-1:0] dat(input int k);
    return 64'h1111_1111_1111_1111 * 64'(k + 1);
  endfunction

  task automatic test_reset();
    i_reset_n  = 1'b0;
    i_req_vld  = 5'h1F;
    i_crdt_rtn = 1'b0;
    repeat (2) @(negedge mclk);
    #1;
    checks++;
    if (o_req_gnt !== 5'h00) begin
      errors++;
      $display("FAIL rst_gnt got %b want 00000", o_req_gnt);
    end
    checks++;
    if (o_vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_vld got %b want 0", o_vld);
    end
    checks++;
    if (o_data !== 64'h0) begin
      errors++;
      $display("FAIL rst_data got %h want 0", o_data);
    end
    checks++;
    if (o_crdt_cnt !== 4'd8) begin
      errors++;
      $display("FAIL rst_cnt got %0d want 8", o_crdt_cnt);
    end
    checks++;
    if (o_crdt_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err got %b want 0", o_crdt_err);
    end
    @(negedge mclk);
    i_reset_n = 1'b1;
    i_req_vld = '0;
  endtask

  task automatic test_rr_drain();
    @(negedge mclk);
    i_req_vld = 5'h1F;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (o_req_gnt !== NR'(1 << (c % 5))) begin
        errors++;
        $display("FAIL drain_gnt c=%0d got %b want %b",
                 c, o_req_gnt, NR'(1 << (c % 5)));
      end
      checks++;
      if (o_crdt_cnt !== CW'(8 - c)) begin
        errors++;
        $display("FAIL drain_cnt c=%0d got %0d want %0d",
                 c, o_crdt_cnt, 8 - c);
      end
      if (c > 0) begin
        checks++;
        if (o_vld !== 1'b1 || o_data !== dat((c - 1) % 5)) begin
          errors++;
          $display("FAIL drain_out c=%0d got %b/%h want 1/%h",
                   c, o_vld, o_data, dat((c - 1) % 5));
        end
      end
      @(negedge mclk);
    end
    #1;
    checks++;
    if (o_req_gnt !== 5'h00 || o_crdt_cnt !== 4'd0) begin
      errors++;
      $display("FAIL drain_empty got %b/%0d want 00000/0",
               o_req_gnt, o_crdt_cnt);
    end
    checks++;
    if (o_vld !== 1'b1 || o_data !== dat(2)) begin
      errors++;
      $display("FAIL drain_last got %b/%h want 1/%h",
               o_vld, o_data, dat(2));
    end
    @(negedge mclk);
    #1;
    checks++;
    if (o_vld !== 1'b0 || o_data !== dat(2)) begin
      errors++;
      $display("FAIL drain_hold got %b/%h want 0/%h",
               o_vld, o_data, dat(2));
    end
  endtask

  task automatic test_crdt_return();
    @(negedge mclk);
    i_req_vld  = 5'b01000;
    i_crdt_rtn = 1'b1;
    #1;
    checks++;
    if (o_req_gnt !== 5'h00) begin
      errors++;
      $display("FAIL rtn_nobypass got %b want 00000", o_req_gnt);
    end
    @(negedge mclk);
    i_crdt_rtn = 1'b0;
    #1;
    checks++;
    if (o_crdt_cnt !== 4'd1 || o_req_gnt !== 5'b01000) begin
      errors++;
      $display("FAIL rtn_gnt got %0d/%b want 1/01000",
               o_crdt_cnt, o_req_gnt);
    end
    @(negedge mclk);
    i_req_vld = '0;
    #1;
    checks++;
    if (o_vld !== 1'b1 || o_data !== dat(3) || o_crdt_cnt !== 4'd0) begin
      errors++;
      $display("FAIL rtn_out got %b/%h/%0d want 1/%h/0",
               o_vld, o_data, o_crdt_cnt, dat(3));
    end
  endtask

  task automatic test_simul();
    i_crdt_rtn = 1'b1;
    repeat (4) @(negedge mclk);
    i_crdt_rtn = 1'b0;
    #1;
    checks++;
    if (o_crdt_cnt !== 4'd4) begin
      errors++;
      $display("FAIL sim_fill got %0d want 4", o_crdt_cnt);
    end
    i_req_vld  = 5'b00001;
    i_crdt_rtn = 1'b1;
    #1;
    checks++;
    if (o_req_gnt !== 5'b00001) begin
      errors++;
      $display("FAIL sim_gnt got %b want 00001", o_req_gnt);
    end
    @(negedge mclk);
    i_req_vld  = '0;
    i_crdt_rtn = 1'b0;
    #1;
    checks++;
    if (o_crdt_cnt !== 4'd4 || o_crdt_err !== 1'b0) begin
      errors++;
      $display("FAIL sim_cnt got %0d/%b want 4/0",
               o_crdt_cnt, o_crdt_err);
    end
    checks++;
    if (o_data !== dat(0)) begin
      errors++;
      $display("FAIL sim_data got %h want %h", o_data, dat(0));
    end
  endtask

  task automatic test_overflow();
    i_crdt_rtn = 1'b1;
    repeat (4) @(negedge mclk);
    #1;
    checks++;
    if (o_crdt_cnt !== 4'd8 || o_crdt_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full got %0d/%b want 8/0",
               o_crdt_cnt, o_crdt_err);
    end
    @(negedge mclk);
    i_crdt_rtn = 1'b0;
    #1;
    checks++;
    if (o_crdt_cnt !== 4'd8 || o_crdt_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_err got %0d/%b want 8/1",
               o_crdt_cnt, o_crdt_err);
    end
    i_req_vld = 5'b00010;
    #1;
    checks++;
    if (o_req_gnt !== 5'b00010) begin
      errors++;
      $display("FAIL ovf_gnt1 got %b want 00010", o_req_gnt);
    end
    @(negedge mclk);
    #1;
    checks++;
    if (o_req_gnt !== 5'b00010) begin
      errors++;
      $display("FAIL ovf_gnt1b got %b want 00010", o_req_gnt);
    end
    @(negedge mclk);
    i_req_vld = 5'b01000;
    #1;
    checks++;
    if (o_req_gnt !== 5'b01000) begin
      errors++;
      $display("FAIL ovf_gnt3 got %b want 01000", o_req_gnt);
    end
    @(negedge mclk);
    i_req_vld = 5'b10010;
    #1;
    checks++;
    if (o_crdt_err !== 1'b1 || o_crdt_cnt !== 4'd5) begin
      errors++;
      $display("FAIL ovf_sticky got %b/%0d want 1/5",
               o_crdt_err, o_crdt_cnt);
    end
  endtask

  task automatic test_wrap();
    #1;
    checks++;
    if (o_req_gnt !== 5'b10000) begin
      errors++;
      $display("FAIL wrap_g4a got %b want 10000", o_req_gnt);
    end
    @(negedge mclk);
    #1;
    checks++;
    if (o_req_gnt !== 5'b00010 || o_data !== dat(4)) begin
      errors++;
      $display("FAIL wrap_g1 got %b/%h want 00010/%h",
               o_req_gnt, o_data, dat(4));
    end
    @(negedge mclk);
    #1;
    checks++;
    if (o_req_gnt !== 5'b10000 || o_data !== dat(1)
        || o_crdt_cnt !== 4'd3) begin
      errors++;
      $display("FAIL wrap_g4b got %b/%h/%0d want 10000/%h/3",
               o_req_gnt, o_data, o_crdt_cnt, dat(1));
    end
  endtask

  task automatic test_reset_mid();
    #2;
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (o_vld !== 1'b0 || o_req_gnt !== 5'h00) begin
      errors++;
      $display("FAIL mid_rst got %b/%b want 0/00000",
               o_vld, o_req_gnt);
    end
    checks++;
    if (o_crdt_cnt !== 4'd8 || o_crdt_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_state got %0d/%b want 8/0",
               o_crdt_cnt, o_crdt_err);
    end
`ifdef MSH_OUT_ARB_PERF_EN
    checks++;
    if (o_stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_stall got %0d want 0", o_stall_cnt);
    end
`endif
    i_req_vld = 5'b10110;
    repeat (2) @(negedge mclk);
    i_reset_n = 1'b1;
    #1;
    checks++;
    if (o_req_gnt !== 5'b00010 || o_crdt_cnt !== 4'd8) begin
      errors++;
      $display("FAIL mid_first got %b/%0d want 00010/8",
               o_req_gnt, o_crdt_cnt);
    end
    @(negedge mclk);
    #1;
    checks++;
    if (o_vld !== 1'b1 || o_data !== dat(1)) begin
      errors++;
      $display("FAIL mid_out got %b/%h want 1/%h",
               o_vld, o_data, dat(1));
    end
    i_req_vld = '0;
  endtask

`ifdef MSH_OUT_ARB_PERF_EN
  task automatic test_perf();
    @(negedge mclk);
    i_reset_n = 1'b0;
    #1;
    @(negedge mclk);
    i_reset_n = 1'b1;
    i_req_vld = 5'h1F;
    repeat (8) @(negedge mclk);
    #1;
    checks++;
    if (o_crdt_cnt !== 4'd0 || o_stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL perf_pre got %0d/%0d want 0/0",
               o_crdt_cnt, o_stall_cnt);
    end
    repeat (10) @(negedge mclk);
    #1;
    checks++;
    if (o_stall_cnt !== 16'd10) begin
      errors++;
      $display("FAIL perf_cnt got %0d want 10", o_stall_cnt);
    end
    i_perf_clr = 1'b1;
    @(negedge mclk);
    i_perf_clr = 1'b0;
    #1;
    checks++;
    if (o_stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL perf_clr got %0d want 0", o_stall_cnt);
    end
    i_req_vld = '0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset_n  = 1'b0;
    i_req_vld  = '0;
    i_crdt_rtn = 1'b0;
`ifdef MSH_OUT_ARB_PERF_EN
    i_perf_clr = 1'b0;
`endif
    for (int k = 0; k < NR; k++) i_req_data[k*DW +: DW] = dat(k);
    test_reset();
    test_rr_drain();
    test_crdt_return();
    test_simul();
    test_overflow();
    test_wrap();
    test_reset_mid();
`ifdef MSH_OUT_ARB_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
